// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter in front of one shared DATA_W-bit register.
// A locked winner keeps the register for consecutive writes until it drops lock.
module dff_write_arbiter #(
  parameter int                N_REQ     = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       sync_reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*DATA_W-1:0]    wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [DATA_W-1:0]          q,
  output logic [$clog2(N_REQ)-1:0]   q_owner,
  output logic                       q_upd,
  output logic                       busy
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t                  state;
  logic [OW-1:0]           ptr;
  logic [N_REQ-1:0]        eligible;
  logic                    win_valid;
  logic [OW-1:0]           win_idx;
  logic [OW-1:0]           cand_idx;
  logic [DATA_W-1:0]       wdata_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
  end

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
    return (idx == OW'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // A requester granted last cycle is masked so an unlocked requester
  // cannot monopolise the register; the search starts at ptr and wraps.
  always_comb begin
    eligible  = req & ~gnt;
    win_valid = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = OW'((int'(ptr) + k) % N_REQ);
      if (!win_valid && eligible[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      // NOTE: the shared register is a plain flop bank, not a memory, so it
      // is reset to RESET_VAL along with the control state.
      state   <= ARB;
      ptr     <= '0;
      q       <= RESET_VAL;
      gnt     <= '0;
      q_owner <= '0;
      q_upd   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt   <= '0;
      q_upd <= 1'b0;
      case (state)
        ARB: begin
          if (win_valid) begin
            q       <= wdata_arr[win_idx];
            gnt     <= onehot(win_idx);
            q_owner <= win_idx;
            q_upd   <= 1'b1;
            ptr     <= next_idx(win_idx);
            if (lock[win_idx]) begin
              state <= LOCKED;
              busy  <= 1'b1;
            end
          end
        end
        LOCKED: begin
          // Only the owner is served; other requests stay pending.
          if (req[q_owner]) begin
            q     <= wdata_arr[q_owner];
            gnt   <= onehot(q_owner);
            q_upd <= 1'b1;
          end
          if (!lock[q_owner]) begin
            state <= ARB;
            busy  <= 1'b0;
            ptr   <= next_idx(q_owner);
          end
        end
        default: begin
          state <= ARB;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt));
  a_upd_matches : assert property (@(posedge clk) disable iff (sync_reset)
                                   q_upd == (|gnt));
  a_busy_state : assert property (@(posedge clk) disable iff (sync_reset)
                                  busy == (state == LOCKED));
`endif

endmodule
